// File: rtl/battle_sequencer.sv
// battle_sequencer: turn-based combat controller for the dungeon engine
//   encounter/player_hp_in start a battle; cmd_valid/cmd/cmd_ready carry attack (5) and run (6);
//   player_hp/enemy_hp expose the battle HP; done/result/flee_dir/hp_wb_valid report the outcome;
//   run_failed and bad_cmd pulse per command; turn_count counts accepted commands.
module battle_sequencer #(
    parameter int HP_W = 16,
    parameter int PLAYER_ATK = 10,
    parameter int ENEMY_ATK = 8,
    parameter int ENEMY_HP_INIT = 30,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            encounter,
    input  logic [HP_W-1:0] player_hp_in,
    input  logic            godmode,
    input  logic            cmd_valid,
    input  logic [3:0]      cmd,
    output logic            cmd_ready,
    output logic            in_battle,
    output logic [HP_W-1:0] player_hp,
    output logic [HP_W-1:0] enemy_hp,
    output logic            run_failed,
    output logic            bad_cmd,
    output logic            done,
    output logic [1:0]      result,
    output logic [1:0]      flee_dir,
    output logic            hp_wb_valid,
    output logic [7:0]      turn_count
);
    typedef enum logic [2:0] {IDLE, WAIT_CMD, P_ATK, RUN_CHK, E_ATK, WIN, LOSE, FLED} state_t;
    localparam logic [HP_W-1:0] P_DMG = HP_W'(PLAYER_ATK);
    localparam logic [HP_W-1:0] E_DMG = HP_W'(ENEMY_ATK);
    state_t state, nxt;
    logic [15:0] lfsr;
    logic [HP_W-1:0] e_sub, p_sub;
    logic accept, escaped;
    // Post-strike HP values drive both the register update and the next-state decision
    always_comb begin
        e_sub = enemy_hp > P_DMG ? enemy_hp - P_DMG : '0;
        p_sub = godmode ? player_hp : (player_hp > E_DMG ? player_hp - E_DMG : '0);
        accept = cmd_ready & cmd_valid;
        escaped = lfsr[1:0] != 2'd0;
        nxt = IDLE;
        case (state)
            IDLE:     nxt = encounter ? (player_hp_in == '0 ? LOSE : WAIT_CMD) : IDLE;
            WAIT_CMD: nxt = !accept ? WAIT_CMD : cmd == 4'd5 ? P_ATK : cmd == 4'd6 ? RUN_CHK : WAIT_CMD;
            P_ATK:    nxt = e_sub == '0 ? WIN : E_ATK;
            RUN_CHK:  nxt = escaped ? FLED : E_ATK;
            E_ATK:    nxt = p_sub == '0 ? LOSE : WAIT_CMD;
            default:  nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lfsr        <= LFSR_SEED;
            cmd_ready   <= 1'b0;
            in_battle   <= 1'b0;
            player_hp   <= '0;
            enemy_hp    <= '0;
            run_failed  <= 1'b0;
            bad_cmd     <= 1'b0;
            done        <= 1'b0;
            result      <= 2'd0;
            flee_dir    <= 2'd0;
            hp_wb_valid <= 1'b0;
            turn_count  <= 8'd0;
        end else begin
            lfsr        <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            state       <= nxt;
            // Status outputs are registered from the next state so they line up with it
            cmd_ready   <= nxt == WAIT_CMD;
            in_battle   <= nxt != IDLE;
            done        <= nxt inside {WIN, LOSE, FLED};
            hp_wb_valid <= nxt inside {WIN, LOSE, FLED};
            bad_cmd     <= accept && cmd != 4'd5 && cmd != 4'd6;
            run_failed  <= state == RUN_CHK && !escaped;
            if (nxt == WIN) result <= 2'd1;
            if (nxt == LOSE) result <= 2'd2;
            if (nxt == FLED) result <= 2'd3;
            if (state == RUN_CHK && escaped) flee_dir <= lfsr[3:2];
            if (state == IDLE && encounter) begin
                player_hp  <= player_hp_in;
                enemy_hp   <= HP_W'(ENEMY_HP_INIT);
                turn_count <= 8'd0;
            end
            if (accept) turn_count <= turn_count + 8'(turn_count != 8'hFF);
            if (state == P_ATK) enemy_hp <= e_sub;
            if (state == E_ATK) player_hp <= p_sub;
        end
    end
endmodule

// File: tb/tb_battle_sequencer.sv
// tb_battle_sequencer: vector table, hand corner cases and randomized battles vs a battle-level model
module tb_battle_sequencer;
    localparam int HP_W = 16;
    logic clk = 1'b0, rst_n = 1'b0, encounter = 1'b0, godmode = 1'b0, cmd_valid = 1'b0;
    logic [HP_W-1:0] player_hp_in = '0;
    logic [3:0] cmd = '0;
    logic cmd_ready, in_battle, run_failed, bad_cmd, done, hp_wb_valid;
    logic [HP_W-1:0] player_hp, enemy_hp;
    logic [1:0] result, flee_dir;
    logic [7:0] turn_count;
    int tests = 0, fails = 0;
    logic [15:0] m_lfsr, o_pred;
    logic [HP_W-1:0] o_p, o_e;
    logic [7:0] o_t;
    logic o_done, o_bad, o_rf, o_wb;
    logic [1:0] o_res, o_dir;
    int o_lat;

    battle_sequencer dut (
        .clk(clk), .rst_n(rst_n), .encounter(encounter), .player_hp_in(player_hp_in),
        .godmode(godmode), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
        .in_battle(in_battle), .player_hp(player_hp), .enemy_hp(enemy_hp),
        .run_failed(run_failed), .bad_cmd(bad_cmd), .done(done), .result(result),
        .flee_dir(flee_dir), .hp_wb_valid(hp_wb_valid), .turn_count(turn_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    always @(posedge clk or negedge rst_n) m_lfsr <= !rst_n ? 16'hACE1 : step(m_lfsr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start(input logic [15:0] hp, input logic g);
        @(negedge clk);
        player_hp_in = hp;
        godmode = g;
        encounter = 1'b1;
        @(negedge clk);
        encounter = 1'b0;
    endtask

    // Issue one command and observe the battle until it is ready again or reports done
    task automatic do_cmd(input logic [3:0] c);
        int n;
        o_done = 0; o_bad = 0; o_rf = 0; o_wb = 0; o_res = 0; o_dir = 0; o_lat = 0;
        cmd = c;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        o_pred = step(m_lfsr);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (n = 1; n <= 8; n++) begin
            @(negedge clk);
            o_bad |= bad_cmd;
            o_rf |= run_failed;
            if (done) begin
                o_done = 1; o_wb = hp_wb_valid; o_res = result; o_dir = flee_dir; o_lat = n;
                break;
            end
            if (cmd_ready) begin o_lat = n; break; end
        end
        o_p = player_hp; o_e = enemy_hp; o_t = turn_count;
    endtask

    typedef struct {
        bit st; logic [15:0] hp; bit god; logic [3:0] c;
        logic [15:0] p, e; logic [7:0] t; logic [1:0] res; bit bad; int lat;
    } vec_t;
    vec_t v[$];

    initial begin
        logic [15:0] mp, me, pd;
        logic [7:0] mt;
        logic [3:0] c;
        logic [1:0] er, edir;
        logic god, over, hit, erf, eb, seen;
        int elat, g;
        v.push_back('{1, 100, 0, 5, 92, 20, 1, 0, 0, 3});
        v.push_back('{0, 0, 0, 5, 84, 10, 2, 0, 0, 3});
        v.push_back('{0, 0, 0, 5, 84, 0, 3, 1, 0, 2});
        v.push_back('{1, 12, 0, 5, 4, 20, 1, 0, 0, 3});
        v.push_back('{0, 0, 0, 5, 0, 10, 2, 2, 0, 3});
        v.push_back('{1, 5, 1, 5, 5, 20, 1, 0, 0, 3});
        v.push_back('{0, 0, 1, 5, 5, 10, 2, 0, 0, 3});
        v.push_back('{0, 0, 1, 5, 5, 0, 3, 1, 0, 2});
        v.push_back('{1, 50, 0, 4, 50, 30, 1, 0, 1, 1});
        v.push_back('{0, 0, 0, 5, 42, 20, 2, 0, 0, 3});
        v.push_back('{0, 0, 0, 0, 42, 20, 3, 0, 1, 1});
        v.push_back('{0, 0, 0, 5, 34, 10, 4, 0, 0, 3});
        v.push_back('{0, 0, 0, 5, 34, 0, 5, 1, 0, 2});

        #12;
        chk("reset_outputs", {cmd_ready, in_battle, player_hp, enemy_hp, run_failed, bad_cmd,
                              done, result, flee_dir, hp_wb_valid, turn_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (v[i]) begin
            if (v[i].st) start(v[i].hp, v[i].god);
            do_cmd(v[i].c);
            chk($sformatf("vec%0d_player_hp", i), o_p, v[i].p);
            chk($sformatf("vec%0d_enemy_hp", i), o_e, v[i].e);
            chk($sformatf("vec%0d_turn_count", i), o_t, v[i].t);
            chk($sformatf("vec%0d_done", i), o_done, v[i].res != 0);
            chk($sformatf("vec%0d_bad_cmd", i), o_bad, v[i].bad);
            chk($sformatf("vec%0d_latency", i), o_lat, v[i].lat);
            if (v[i].res != 0) begin
                chk($sformatf("vec%0d_result", i), o_res, v[i].res);
                chk($sformatf("vec%0d_hp_wb_valid", i), o_wb, 1);
            end
        end
        godmode = 1'b0;

        start(0, 0);
        chk("zero_hp_done", {done, hp_wb_valid, result}, {2'b11, 2'd2});
        @(negedge clk);
        chk("zero_hp_after", {in_battle, cmd_ready}, 0);

        start(100, 0);
        encounter = 1'b1;
        player_hp_in = 7;
        @(negedge clk);
        encounter = 1'b0;
        chk("mid_encounter_ignored", {player_hp, enemy_hp, turn_count, cmd_ready}, {16'd100, 16'd30, 8'd0, 1'b1});

        g = 0;
        while (step(m_lfsr) & 16'h3 && g < 64) begin @(negedge clk); g++; end
        do_cmd(6);
        chk("run_fail_pulse", o_rf, 1);
        chk("run_fail_hp", {o_p, o_e, o_t}, {16'd92, 16'd30, 8'd1});
        chk("run_fail_latency", o_lat, 3);
        g = 0;
        while (!(step(m_lfsr) & 16'h3) && g < 64) begin @(negedge clk); g++; end
        pd = step(m_lfsr);
        do_cmd(6);
        chk("run_ok_result", {o_done, o_res}, {1'b1, 2'd3});
        chk("run_ok_flee_dir", o_dir, pd[3:2]);
        chk("run_ok_hp", {o_p, o_e, o_t}, {16'd92, 16'd30, 8'd2});
        chk("run_ok_latency", o_lat, 2);

        start(100, 0);
        repeat (260) do_cmd(4);
        chk("turn_saturate", o_t, 255);

        @(negedge clk);
        cmd = 5;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_mid_battle", {cmd_ready, in_battle, player_hp, enemy_hp, run_failed, bad_cmd,
                                 done, result, flee_dir, hp_wb_valid, turn_count}, 0);
        seen = 0;
        repeat (3) begin @(negedge clk); seen |= done | hp_wb_valid; end
        rst_n = 1'b1;
        chk("reset_no_done", seen, 0);
        start(40, 0);
        do_cmd(5);
        chk("after_reset_battle", {o_p, o_e, o_t, o_done}, {16'd32, 16'd20, 8'd1, 1'b0});
        chk("after_reset_latency", o_lat, 3);
        do_cmd(5); do_cmd(5);
        chk("after_reset_win", {o_done, o_res}, {1'b1, 2'd1});

        for (int b = 0; b < 30; b++) begin
            mp = 16'($urandom_range(0, 60));
            god = $urandom_range(0, 3) == 0;
            me = 30; mt = 0; over = 0;
            start(mp, god);
            if (mp == 0) begin
                chk($sformatf("rand%0d_zero_hp", b), {done, result}, {1'b1, 2'd2});
                over = 1;
            end
            for (int k = 0; k < 60 && !over; k++) begin
                g = $urandom_range(0, 13);
                c = k >= 30 ? 4'd5 : $urandom_range(0, 1) ? 4'd5 : $urandom_range(0, 2) != 0 ? 4'd6 : 4'(g < 5 ? g : g + 2);
                do_cmd(c);
                mt = mt == 8'hFF ? mt : mt + 1;
                er = 0; edir = 0; erf = 0; eb = 0; hit = 0; elat = 1;
                if (c == 5) begin
                    me = me > 10 ? me - 10 : 0;
                    if (me == 0) begin er = 1; elat = 2; end else hit = 1;
                end else if (c == 6) begin
                    if (o_pred[1:0] != 0) begin er = 3; edir = o_pred[3:2]; elat = 2; end
                    else begin erf = 1; hit = 1; end
                end else eb = 1;
                if (hit) begin
                    if (!god) mp = mp > 8 ? mp - 8 : 0;
                    elat = 3;
                    if (mp == 0) er = 2;
                end
                chk($sformatf("rand%0d_%0d_state", b, k), {o_p, o_e, o_t}, {mp, me, mt});
                chk($sformatf("rand%0d_%0d_flags", b, k), {o_done, o_res, o_bad, o_rf}, {er != 0, er, eb, erf});
                chk($sformatf("rand%0d_%0d_latency", b, k), o_lat, elat);
                if (er == 3) chk($sformatf("rand%0d_%0d_flee_dir", b, k), o_dir, edir);
                over = er != 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
